// File: rtl/dm_sba_arbiter.sv
// ============================================================================
// Module   : dm_sba_arbiter
// Purpose  : Round-robin sharing of the debug-module system-bus master port,
//            one outstanding transaction, with a response watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dm_sba_arbiter #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         dmactive_i,
    input  logic [NumReq-1:0]            req_i,
    input  logic [NumReq-1:0][31:0]      add_i,
    input  logic [NumReq-1:0]            we_i,
    input  logic [NumReq-1:0][31:0]      wdata_i,
    input  logic [NumReq-1:0][3:0]       be_i,
    output logic [NumReq-1:0]            gnt_o,
    output logic [NumReq-1:0]            r_valid_o,
    output logic [NumReq-1:0]            r_err_o,
    output logic [NumReq-1:0]            r_other_err_o,
    output logic [31:0]                  r_rdata_o,
    output logic                         master_req_o,
    output logic [31:0]                  master_add_o,
    output logic                         master_we_o,
    output logic [31:0]                  master_wdata_o,
    output logic [3:0]                   master_be_o,
    input  logic                         master_gnt_i,
    input  logic                         master_r_valid_i,
    input  logic                         master_r_err_i,
    input  logic                         master_r_other_err_i,
    input  logic [31:0]                  master_r_rdata_i,
    output logic                         busy_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam bit          TmoEn = (TimeoutCycles > 0);
    localparam logic [CntW-1:0] TmoLast = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;
    localparam logic [IdxW:0]   NumReqW = (IdxW + 1)'(NumReq);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]      state_q;
    logic [IdxW-1:0] owner_q;
    logic [IdxW-1:0] rr_ptr_q;
    logic [CntW-1:0] tmo_cnt_q;

    logic [IdxW:0]   scan_sum;
    logic            win_found;
    logic [IdxW-1:0] win_idx;
    logic [IdxW-1:0] sel_idx;
    logic [IdxW-1:0] sel_next;
    logic [NumReq-1:0] sel_onehot;
    logic [NumReq-1:0] own_onehot;
    logic            issue;
    logic            granted;
    logic            tmo_hit;
    logic            rsp_real;
    logic            rsp_tmo;

    // Scan upward from rr_ptr_q, wrapping, for the first active request.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        scan_sum  = '0;
        for (int i = 0; i < NumReq; i++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IdxW + 1)'(i);
            if (scan_sum >= NumReqW) begin
                scan_sum = scan_sum - NumReqW;
            end
            if (!win_found && req_i[scan_sum[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_sum[IdxW-1:0];
            end
        end
    end

    // Once a request is presented it is locked to owner_q until granted.
    assign sel_idx    = (state_q == S_IDLE) ? win_idx : owner_q;
    assign sel_next   = (sel_idx == IdxW'(NumReq - 1)) ? '0 : sel_idx + IdxW'(1);
    assign sel_onehot = NumReq'(1) << sel_idx;
    assign own_onehot = NumReq'(1) << owner_q;

    assign issue   = ((state_q == S_IDLE) && dmactive_i && win_found) ||
                     ((state_q == S_REQ) && req_i[owner_q]);
    assign granted = issue && master_gnt_i;

    assign tmo_hit  = TmoEn && (tmo_cnt_q == TmoLast);
    assign rsp_real = (state_q == S_WAIT) && master_r_valid_i;
    assign rsp_tmo  = (state_q == S_WAIT) && !master_r_valid_i && tmo_hit;

    assign master_req_o   = issue;
    assign master_add_o   = add_i[sel_idx];
    assign master_we_o    = we_i[sel_idx];
    assign master_wdata_o = wdata_i[sel_idx];
    assign master_be_o    = be_i[sel_idx];

    assign gnt_o         = granted ? sel_onehot : '0;
    assign r_valid_o     = (rsp_real || rsp_tmo) ? own_onehot : '0;
    assign r_err_o       = (rsp_real && master_r_err_i) ? own_onehot : '0;
    assign r_other_err_o = ((rsp_real && master_r_other_err_i) || rsp_tmo) ? own_onehot : '0;
    assign r_rdata_o     = rsp_real ? master_r_rdata_i : '0;
    assign busy_o        = (state_q != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            tmo_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tmo_cnt_q <= '0;
                    if (issue) begin
                        owner_q <= win_idx;
                        if (master_gnt_i) begin
                            rr_ptr_q <= sel_next;
                            state_q  <= S_WAIT;
                        end else begin
                            state_q  <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (!req_i[owner_q]) begin
                        state_q <= S_IDLE;
                    end else if (master_gnt_i) begin
                        rr_ptr_q <= sel_next;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (master_r_valid_i) begin
                        state_q   <= S_IDLE;
                        tmo_cnt_q <= '0;
                    end else if (tmo_hit) begin
                        state_q   <= S_DRAIN;
                        tmo_cnt_q <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CntW'(1);
                    end
                end
                S_DRAIN: begin
                    // A late response here belongs to an already-failed access.
                    if (master_r_valid_i || tmo_hit) begin
                        state_q   <= S_IDLE;
                        tmo_cnt_q <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CntW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dm_sba_arbiter.sv
// ============================================================================
// Module   : tb_dm_sba_arbiter
// Purpose  : Directed bench for dm_sba_arbiter with a per-cycle reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dm_sba_arbiter;

    localparam int NR  = 2;
    localparam int TMO = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              dmactive_i = 1'b1;
    logic [NR-1:0]     req_i = '0;
    logic [NR-1:0][31:0] add_i = '0;
    logic [NR-1:0]     we_i = '0;
    logic [NR-1:0][31:0] wdata_i = '0;
    logic [NR-1:0][3:0] be_i = '0;
    logic [NR-1:0]     gnt_o;
    logic [NR-1:0]     r_valid_o;
    logic [NR-1:0]     r_err_o;
    logic [NR-1:0]     r_other_err_o;
    logic [31:0]       r_rdata_o;
    logic              master_req_o;
    logic [31:0]       master_add_o;
    logic              master_we_o;
    logic [31:0]       master_wdata_o;
    logic [3:0]        master_be_o;
    logic              master_gnt_i = 1'b0;
    logic              master_r_valid_i = 1'b0;
    logic              master_r_err_i = 1'b0;
    logic              master_r_other_err_i = 1'b0;
    logic [31:0]       master_r_rdata_i = '0;
    logic              busy_o;

    int total = 0;
    int bad   = 0;

    dm_sba_arbiter #(.NumReq(NR), .TimeoutCycles(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .dmactive_i(dmactive_i),
        .req_i(req_i), .add_i(add_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_err_o(r_err_o),
        .r_other_err_o(r_other_err_o), .r_rdata_o(r_rdata_o),
        .master_req_o(master_req_o), .master_add_o(master_add_o),
        .master_we_o(master_we_o), .master_wdata_o(master_wdata_o),
        .master_be_o(master_be_o), .master_gnt_i(master_gnt_i),
        .master_r_valid_i(master_r_valid_i), .master_r_err_i(master_r_err_i),
        .master_r_other_err_i(master_r_other_err_i),
        .master_r_rdata_i(master_r_rdata_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: transaction phase 0 free, 1 locked awaiting grant,
    // 2 outstanding, 3 timed out and draining.
    int m_phase = 0;
    int m_owner = 0;
    int m_prio  = 0;
    int m_age   = 0;
    int w;
    int j;
    logic [NR-1:0] e_gnt, e_rv, e_err, e_oth;
    logic [31:0]   e_rd;
    logic          e_mreq, e_busy;
    int            e_sel;

    initial forever begin
        @(negedge clk_i);
        e_gnt = '0; e_rv = '0; e_err = '0; e_oth = '0; e_rd = '0;
        e_mreq = 1'b0; e_sel = 0;
        e_busy = (m_phase != 0);
        if (!rst_ni) begin
            m_phase = 0; m_owner = 0; m_prio = 0; m_age = 0;
            e_busy = 1'b0;
        end else begin
            case (m_phase)
                0: if (dmactive_i && req_i != '0) begin
                    w = -1;
                    for (int k = 0; k < NR; k++) begin
                        j = (m_prio + k) % NR;
                        if (w < 0 && req_i[j]) w = j;
                    end
                    e_mreq = 1'b1; e_sel = w; m_owner = w;
                    if (master_gnt_i) begin
                        e_gnt[w] = 1'b1; m_prio = (w + 1) % NR; m_phase = 2; m_age = 0;
                    end else begin
                        m_phase = 1;
                    end
                end
                1: if (req_i[m_owner]) begin
                    e_mreq = 1'b1; e_sel = m_owner;
                    if (master_gnt_i) begin
                        e_gnt[m_owner] = 1'b1; m_prio = (m_owner + 1) % NR;
                        m_phase = 2; m_age = 0;
                    end
                end else begin
                    m_phase = 0;
                end
                2: if (master_r_valid_i) begin
                    e_rv[m_owner] = 1'b1;
                    e_err[m_owner] = master_r_err_i;
                    e_oth[m_owner] = master_r_other_err_i;
                    e_rd = master_r_rdata_i;
                    m_phase = 0;
                end else if (m_age == TMO - 1) begin
                    e_rv[m_owner] = 1'b1; e_oth[m_owner] = 1'b1;
                    m_phase = 3; m_age = 0;
                end else begin
                    m_age++;
                end
                default: if (master_r_valid_i || m_age == TMO - 1) begin
                    m_phase = 0; m_age = 0;
                end else begin
                    m_age++;
                end
            endcase
        end
        chk("gnt", gnt_o, e_gnt);
        chk("r_valid", r_valid_o, e_rv);
        chk("master_req", master_req_o, e_mreq);
        chk("busy", busy_o, e_busy);
        if (e_mreq) begin
            chk("master_add", master_add_o, add_i[e_sel]);
            chk("master_we", master_we_o, we_i[e_sel]);
            chk("master_wdata", master_wdata_o, wdata_i[e_sel]);
            chk("master_be", master_be_o, be_i[e_sel]);
        end
        if (e_rv != '0) begin
            chk("r_err", r_err_o, e_err);
            chk("r_other_err", r_other_err_o, e_oth);
            chk("r_rdata", r_rdata_o, e_rd);
        end
    end

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_bus();
        req_i = '0; master_gnt_i = 1'b0; master_r_valid_i = 1'b0;
        master_r_err_i = 1'b0; master_r_other_err_i = 1'b0; master_r_rdata_i = '0;
        we_i = '0; dmactive_i = 1'b1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clr_bus();
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    int order[$];

    initial begin
        add_i[0] = 32'h100; add_i[1] = 32'h300;
        wdata_i[0] = 32'hA5A5_0001; wdata_i[1] = 32'h5A5A_0002;
        be_i[0] = 4'hF; be_i[1] = 4'h3;
        #2;
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_mreq", master_req_o, 1'b0);
        do_reset();

        // Single read from requester 0
        req_i = 2'b01; master_gnt_i = 1'b1;
        @(negedge clk_i); chk("t1_gnt", gnt_o, 2'b01);
        nxt(); req_i = '0; master_gnt_i = 1'b0;
        nxt();
        nxt(); master_r_valid_i = 1'b1; master_r_rdata_i = 32'hDEADBEEF;
        @(negedge clk_i);
        chk("t1_rvalid", r_valid_o, 2'b01);
        chk("t1_rdata", r_rdata_o, 32'hDEADBEEF);
        chk("t1_busy", busy_o, 1'b1);
        nxt(); clr_bus();
        @(negedge clk_i); chk("t1_idle", busy_o, 1'b0);

        // Round robin under continuous contention
        do_reset();
        req_i = 2'b11; master_gnt_i = 1'b1; master_r_valid_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (gnt_o == 2'b01) order.push_back(0);
            else if (gnt_o == 2'b10) order.push_back(1);
            nxt();
        end
        clr_bus();
        chk("t2_count", order.size(), 4);
        if (order.size() == 4) begin
            chk("t2_g0", order[0], 0); chk("t2_g1", order[1], 1);
            chk("t2_g2", order[2], 0); chk("t2_g3", order[3], 1);
        end

        // Locked request during delayed grant, then bus error to requester 1
        do_reset();
        add_i[0] = 32'h200;
        req_i = 2'b01;
        @(negedge clk_i); chk("t3_add_c0", master_add_o, 32'h200);
        for (int c = 1; c < 5; c++) begin
            nxt();
            if (c == 2) req_i = 2'b11;
            @(negedge clk_i); chk("t3_add_hold", master_add_o, 32'h200);
        end
        nxt(); master_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("t3_gnt0", gnt_o, 2'b01);
        chk("t3_add_gnt", master_add_o, 32'h200);
        nxt(); req_i = 2'b10; master_gnt_i = 1'b0; master_r_valid_i = 1'b1;
        nxt(); master_r_valid_i = 1'b0; master_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("t3_gnt1", gnt_o, 2'b10);
        chk("t3_add1", master_add_o, 32'h300);
        nxt(); req_i = '0; master_gnt_i = 1'b0;
        master_r_valid_i = 1'b1; master_r_err_i = 1'b1;
        @(negedge clk_i);
        chk("t5_rvalid", r_valid_o, 2'b10);
        chk("t5_err", r_err_o, 2'b10);
        chk("t5_other", r_other_err_o, 2'b00);
        nxt(); clr_bus();

        // Watchdog on a granted write, late response swallowed
        do_reset();
        req_i = 2'b01; we_i = 2'b01; master_gnt_i = 1'b1;
        @(negedge clk_i); chk("t4_gnt", gnt_o, 2'b01);
        for (int c = 1; c <= 8; c++) begin
            nxt();
            if (c == 1) begin req_i = '0; master_gnt_i = 1'b0; end
            @(negedge clk_i);
            if (c == 7) chk("t4_no_rv_yet", r_valid_o, 2'b00);
            if (c == 8) begin
                chk("t4_tmo_rv", r_valid_o, 2'b01);
                chk("t4_tmo_other", r_other_err_o, 2'b01);
                chk("t4_tmo_err", r_err_o, 2'b00);
                chk("t4_tmo_rdata", r_rdata_o, 32'h0);
            end
        end
        nxt(); req_i = 2'b10;
        @(negedge clk_i); chk("t4_drain_mreq", master_req_o, 1'b0);
        nxt(); master_r_valid_i = 1'b1; master_r_rdata_i = 32'h1111_2222;
        @(negedge clk_i);
        chk("t4_swallow", r_valid_o, 2'b00);
        chk("t4_drain_busy", busy_o, 1'b1);
        nxt(); master_r_valid_i = 1'b0; master_gnt_i = 1'b1;
        @(negedge clk_i); chk("t4_next_gnt", gnt_o, 2'b10);
        nxt(); req_i = '0; master_gnt_i = 1'b0; master_r_valid_i = 1'b1;
        @(negedge clk_i); chk("t4_next_rv", r_valid_o, 2'b10);
        nxt(); clr_bus();

        // dmactive gating, in-flight completion, async reset
        do_reset();
        dmactive_i = 1'b0; req_i = 2'b01; master_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("t6_mreq_off", master_req_o, 1'b0);
        chk("t6_gnt_off", gnt_o, 2'b00);
        nxt();
        @(negedge clk_i); chk("t6_gnt_off2", gnt_o, 2'b00);
        nxt(); dmactive_i = 1'b1;
        @(negedge clk_i); chk("t6_gnt_on", gnt_o, 2'b01);
        nxt(); dmactive_i = 1'b0; req_i = '0; master_gnt_i = 1'b0;
        nxt(); master_r_valid_i = 1'b1; master_r_rdata_i = 32'h0000_1234;
        @(negedge clk_i);
        chk("t6_inflight_rv", r_valid_o, 2'b01);
        chk("t6_inflight_rd", r_rdata_o, 32'h0000_1234);
        nxt(); master_r_valid_i = 1'b0; dmactive_i = 1'b1; req_i = 2'b01; master_gnt_i = 1'b1;
        nxt(); req_i = '0; master_gnt_i = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        chk("t6_async_busy", busy_o, 1'b0);
        chk("t6_async_gnt", gnt_o, 2'b00);
        @(negedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        master_r_valid_i = 1'b1; master_r_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk_i); chk("t6_stray_rv", r_valid_o, 2'b00);
        nxt(); clr_bus();

        // Mixed traffic checked only by the model
        for (int c = 0; c < 300; c++) begin
            nxt();
            dmactive_i = ($urandom_range(0, 9) != 0);
            req_i = NR'($urandom);
            add_i[0] = $urandom; add_i[1] = $urandom;
            we_i = NR'($urandom);
            wdata_i[0] = $urandom; wdata_i[1] = $urandom;
            be_i[0] = 4'($urandom); be_i[1] = 4'($urandom);
            master_gnt_i = 1'($urandom);
            master_r_valid_i = ($urandom_range(0, 3) == 0);
            master_r_err_i = 1'($urandom);
            master_r_other_err_i = 1'($urandom);
            master_r_rdata_i = $urandom;
        end
        nxt(); clr_bus();
        nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
